// File: rtl/mem_lsu.sv
// Memory-access stage: issues loads/stores over a req/ack data bus, stalls
// the pipeline while the access is outstanding, and formats load data for
// the write-back bundle. Non-memory instructions pass straight through.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_whilo,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stallreq,
  output logic        align_err
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] rdata_q;

  logic is_load, is_store, is_mem, is_byte, is_half, is_word, is_signed;
  logic misalign, go, req;
  logic [1:0]  lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign lane = ex_mem_addr[1:0];

  // Decode the opcode into access class, size and signedness.
  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_word   = 1'b0;
    is_signed = 1'b0;
    case (ex_aluop)
      OP_LB:  begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      OP_LH:  begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      OP_LW:  begin is_load  = 1'b1; is_word = 1'b1; end
      OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
      OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
      OP_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
      OP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:  begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem   = is_load | is_store;
  assign misalign = (is_half & lane[0]) | (is_word & (lane != 2'b00));
  assign go       = is_mem & ~misalign;
  assign req      = ((state_q == IDLE) & go) | (state_q == BUSY);

  // Next-state logic for the access handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = bus_ack ? DONE : BUSY;
      BUSY:    if (bus_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and load-data capture on entry to DONE.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != DONE && state_d == DONE && is_load)
        rdata_q <= bus_rdata;
    end
  end

  // Select the big-endian lane of the captured word and extend it.
  always_comb begin
    case (lane)
      2'b00:   ld_byte = rdata_q[31:24];
      2'b01:   ld_byte = rdata_q[23:16];
      2'b10:   ld_byte = rdata_q[15:8];
      default: ld_byte = rdata_q[7:0];
    endcase
    ld_half = lane[1] ? rdata_q[15:0] : rdata_q[31:16];
    if (is_byte)
      load_data = {{24{is_signed & ld_byte[7]}}, ld_byte};
    else if (is_half)
      load_data = {{16{is_signed & ld_half[15]}}, ld_half};
    else
      load_data = rdata_q;
  end

  // Write-back bundle, bus request and status; everything reads 0 during reset.
  always_comb begin
    mem_wd    = '0;
    mem_wreg  = 1'b0;
    mem_wdata = '0;
    mem_hi    = '0;
    mem_lo    = '0;
    mem_whilo = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_sel   = '0;
    bus_wdata = '0;
    stallreq  = 1'b0;
    align_err = 1'b0;
    if (!rst) begin
      mem_wd    = ex_wd;
      mem_hi    = ex_hi;
      mem_lo    = ex_lo;
      mem_whilo = ex_whilo;
      mem_wdata = (is_load && state_q == DONE) ? load_data : ex_wdata;
      mem_wreg  = is_load ? (ex_wreg & (state_q == DONE) & ~misalign)
                          : (ex_wreg & ~misalign);
      align_err = is_mem & misalign;
      stallreq  = req;
      bus_req   = req;
      if (req) begin
        bus_we   = is_store;
        bus_addr = {ex_mem_addr[31:2], 2'b00};
        if (is_byte)      bus_sel = 4'b1000 >> lane;
        else if (is_half) bus_sel = lane[1] ? 4'b0011 : 4'b1100;
        else              bus_sel = 4'b1111;
        if (is_store) begin
          if (is_byte)      bus_wdata = {4{ex_reg2[7:0]}};
          else if (is_half) bus_wdata = {2{ex_reg2[15:0]}};
          else              bus_wdata = ex_reg2;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a vector table of single accesses with a
// zero-wait ack, plus hand sequences for wait states and reset mid-access.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic        ex_whilo;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr, ex_reg2;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stallreq, align_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .rst(rst),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stallreq(stallreq), .align_err(align_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic ack, input logic [31:0] rdata);
    ex_aluop    = op;
    ex_mem_addr = addr;
    ex_reg2     = reg2;
    ex_wd       = wd;
    ex_wreg     = wreg;
    ex_wdata    = wdata;
    bus_ack     = ack;
    bus_rdata   = rdata;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_baddr;
    logic [31:0] e_bwdata;
    logic        e_align;
    logic        e_wreg;
    logic [31:0] e_done_wdata;
    logic        e_done_wreg;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // op, addr, reg2, wd, wreg, wdata, rdata, req, we, sel, baddr, bwdata, align, wreg, done_wdata, done_wreg
    vecs[0]  = '{8'h21, 32'h0,   32'h0,        5'd3,  1'b1, 32'h12345678, 32'h0,
                 1'b0, 1'b0, 4'b0000, 32'h0,   32'h0,        1'b0, 1'b1, 32'h12345678, 1'b1};
    vecs[1]  = '{8'hE5, 32'h202, 32'h0,        5'd4,  1'b1, 32'h00000055, 32'hAAAA8001,
                 1'b1, 1'b0, 4'b0011, 32'h200, 32'h0,        1'b0, 1'b0, 32'h00008001, 1'b1};
    vecs[2]  = '{8'hE8, 32'h303, 32'hDEADBEEF, 5'd0,  1'b0, 32'h00000303, 32'h0,
                 1'b1, 1'b1, 4'b0001, 32'h300, 32'hEFEFEFEF, 1'b0, 1'b0, 32'h00000303, 1'b0};
    vecs[3]  = '{8'hE3, 32'h402, 32'h0,        5'd5,  1'b1, 32'h00000402, 32'h0,
                 1'b0, 1'b0, 4'b0000, 32'h0,   32'h0,        1'b1, 1'b0, 32'h00000402, 1'b0};
    vecs[4]  = '{8'hE1, 32'h010, 32'h0,        5'd6,  1'b1, 32'h00000010, 32'h80011234,
                 1'b1, 1'b0, 4'b1100, 32'h010, 32'h0,        1'b0, 1'b0, 32'hFFFF8001, 1'b1};
    vecs[5]  = '{8'hE0, 32'h013, 32'h0,        5'd7,  1'b1, 32'h00000013, 32'h0000007F,
                 1'b1, 1'b0, 4'b0001, 32'h010, 32'h0,        1'b0, 1'b0, 32'h0000007F, 1'b1};
    vecs[6]  = '{8'hE4, 32'h022, 32'h0,        5'd8,  1'b1, 32'h00000022, 32'h1234F600,
                 1'b1, 1'b0, 4'b0010, 32'h020, 32'h0,        1'b0, 1'b0, 32'h000000F6, 1'b1};
    vecs[7]  = '{8'hE9, 32'h042, 32'h1111ABCD, 5'd0,  1'b0, 32'h00000042, 32'h0,
                 1'b1, 1'b1, 4'b0011, 32'h040, 32'hABCDABCD, 1'b0, 1'b0, 32'h00000042, 1'b0};
    vecs[8]  = '{8'hEB, 32'h044, 32'hCAFEF00D, 5'd0,  1'b0, 32'h00000044, 32'h0,
                 1'b1, 1'b1, 4'b1111, 32'h044, 32'hCAFEF00D, 1'b0, 1'b0, 32'h00000044, 1'b0};
    vecs[9]  = '{8'hE3, 32'h048, 32'h0,        5'd9,  1'b1, 32'h00000048, 32'h89ABCDEF,
                 1'b1, 1'b0, 4'b1111, 32'h048, 32'h0,        1'b0, 1'b0, 32'h89ABCDEF, 1'b1};
    vecs[10] = '{8'hE9, 32'h051, 32'h12345678, 5'd0,  1'b0, 32'h00000051, 32'h0,
                 1'b0, 1'b0, 4'b0000, 32'h0,   32'h0,        1'b1, 1'b0, 32'h00000051, 1'b0};
    vecs[11] = '{8'hE5, 32'h033, 32'h0,        5'd10, 1'b1, 32'h00000033, 32'hFFFFFFFF,
                 1'b0, 1'b0, 4'b0000, 32'h0,   32'h0,        1'b1, 1'b0, 32'h00000033, 1'b0};

    ex_hi    = 32'h0000_1111;
    ex_lo    = 32'h2222_0000;
    ex_whilo = 1'b1;
    drive(8'h21, 32'h0, 32'h0, 5'd3, 1'b1, 32'h12345678, 1'b1, 32'hFFFFFFFF);

    // Reset: every output reads 0 even with live inputs.
    rst = 1'b1;
    #12;
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wd",    {27'h0, mem_wd}, 32'h0);
    check("rst_mem_wreg",  {31'h0, mem_wreg}, 32'h0);
    check("rst_mem_hi",    mem_hi, 32'h0);
    check("rst_mem_whilo", {31'h0, mem_whilo}, 32'h0);
    check("rst_stallreq",  {31'h0, stallreq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table: each vector gets a zero-wait ack, then a DONE-cycle check, then a NOP cycle.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].addr, vecs[i].reg2, vecs[i].wd, vecs[i].wreg,
            vecs[i].wdata, 1'b1, vecs[i].rdata);
      #1;
      check($sformatf("v%0d_bus_req", i),   {31'h0, bus_req},   {31'h0, vecs[i].e_req});
      check($sformatf("v%0d_stallreq", i),  {31'h0, stallreq},  {31'h0, vecs[i].e_req});
      check($sformatf("v%0d_bus_we", i),    {31'h0, bus_we},    {31'h0, vecs[i].e_we});
      check($sformatf("v%0d_bus_sel", i),   {28'h0, bus_sel},   {28'h0, vecs[i].e_sel});
      check($sformatf("v%0d_bus_addr", i),  bus_addr,           vecs[i].e_baddr);
      check($sformatf("v%0d_bus_wdata", i), bus_wdata,          vecs[i].e_bwdata);
      check($sformatf("v%0d_align_err", i), {31'h0, align_err}, {31'h0, vecs[i].e_align});
      check($sformatf("v%0d_mem_wreg", i),  {31'h0, mem_wreg},  {31'h0, vecs[i].e_wreg});
      check($sformatf("v%0d_mem_wdata", i), mem_wdata,          vecs[i].wdata);
      check($sformatf("v%0d_mem_wd", i),    {27'h0, mem_wd},    {27'h0, vecs[i].wd});
      check($sformatf("v%0d_mem_hilo", i),  mem_hi ^ mem_lo,    32'h2222_1111);
      check($sformatf("v%0d_mem_whilo", i), {31'h0, mem_whilo}, 32'h1);
      @(negedge clk);
      check($sformatf("v%0d_done_wdata", i), mem_wdata,          vecs[i].e_done_wdata);
      check($sformatf("v%0d_done_wreg", i),  {31'h0, mem_wreg},  {31'h0, vecs[i].e_done_wreg});
      check($sformatf("v%0d_done_stall", i), {31'h0, stallreq},  32'h0);
      check($sformatf("v%0d_done_req", i),   {31'h0, bus_req},   32'h0);
      @(negedge clk);
      drive(8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    end

    // LB with two request cycles before the ack.
    @(negedge clk);
    drive(8'hE0, 32'h101, 32'h0, 5'd11, 1'b1, 32'h00000101, 1'b0, 32'h0);
    #1;
    check("lb_sel",  {28'h0, bus_sel}, 32'h4);
    check("lb_addr", bus_addr, 32'h100);
    begin
      int stalls = 0;
      int cyc    = 0;
      while (stallreq && cyc < 10) begin
        stalls++;
        check("lb_wait_wdata", mem_wdata, 32'h00000101);
        check("lb_wait_wreg",  {31'h0, mem_wreg}, 32'h0);
        if (stalls == 2) begin
          bus_ack   = 1'b1;
          bus_rdata = 32'h11F23344;
        end
        @(negedge clk);
        #1;
        cyc++;
      end
      check("lb_stall_cycles", stalls, 2);
    end
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    check("lb_done_wdata", mem_wdata, 32'hFFFFFFF2);
    check("lb_done_wreg",  {31'h0, mem_wreg}, 32'h1);
    @(negedge clk);
    drive(8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Back-to-back: a load arriving right after DONE issues immediately.
    drive(8'hE3, 32'h200, 32'h0, 5'd12, 1'b1, 32'h0, 1'b1, 32'h5A5A5A5A);
    #1;
    check("b2b_req", {31'h0, bus_req}, 32'h1);
    @(negedge clk);
    check("b2b_done_wdata", mem_wdata, 32'h5A5A5A5A);
    @(negedge clk);
    drive(8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Reset asserted while BUSY abandons the access.
    @(negedge clk);
    drive(8'hE3, 32'h400, 32'h0, 5'd13, 1'b1, 32'h77, 1'b0, 32'h0);
    @(negedge clk);
    check("busy_req", {31'h0, bus_req}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_busy_req",   {31'h0, bus_req},  32'h0);
    check("rst_busy_stall", {31'h0, stallreq}, 32'h0);
    check("rst_busy_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(8'h21, 32'h0, 32'h0, 5'd14, 1'b1, 32'h0000A5A5, 1'b0, 32'h0);
    #1;
    check("post_rst_stall", {31'h0, stallreq}, 32'h0);
    check("post_rst_req",   {31'h0, bus_req},  32'h0);
    check("post_rst_wdata", mem_wdata, 32'h0000A5A5);
    check("post_rst_wreg",  {31'h0, mem_wreg}, 32'h1);
    @(negedge clk);
    // A load now sees IDLE: zero-wait ack lands in DONE the next cycle.
    drive(8'hE3, 32'h404, 32'h0, 5'd15, 1'b1, 32'h0, 1'b1, 32'h0BADF00D);
    @(negedge clk);
    check("post_rst_load", mem_wdata, 32'h0BADF00D);
    bus_ack = 1'b0;
    @(negedge clk);
    drive(8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage of the five-stage pipeline: sits between the EX/MEM register and `mem_wb`. It issues byte, halfword and word loads and stores to the data bus with a req/ack handshake, and stalls the pipeline until the access completes. It formats load data and drives the write-back bundle consumed by `mem_wb`. Non-memory instructions pass straight through with zero added latency.

## Interface
- No parameters. Opcodes use the `defines.v` aluop encodings:
  - Loads: LB=8'hE0, LH=8'hE1, LW=8'hE3, LBU=8'hE4, LHU=8'hE5.
  - Stores: SB=8'hE8, SH=8'hE9, SW=8'hEB.
- Ports:
  - `clk` in 1: sole clock, rising edge.
  - `rst` in 1: asynchronous, active-high reset.
  - `ex_wd` in 5, `ex_wreg` in 1, `ex_wdata` in 32: destination address, write enable and ALU result from EX/MEM.
  - `ex_hi`, `ex_lo` in 32, `ex_whilo` in 1: HI/LO values and write enable from EX/MEM.
  - `ex_aluop` in 8: operation code.
  - `ex_mem_addr` in 32: effective address.
  - `ex_reg2` in 32: store source data.
  - `mem_wd` out 5, `mem_wreg` out 1, `mem_wdata` out 32, `mem_hi`/`mem_lo` out 32, `mem_whilo` out 1: write-back bundle to `mem_wb`.
  - `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32, `bus_sel` out 4, `bus_wdata` out 32: data-bus request.
  - `bus_ack` in 1, `bus_rdata` in 32: data-bus response.
  - `stallreq` out 1: stall request to the pipeline controller.
  - `align_err` out 1: misaligned access flag, level while the instruction is present.

## Operation
- FSM states:
  - IDLE: accept the instruction.
  - BUSY: request outstanding.
  - DONE: result valid for one cycle.
  - State and 32-bit `rdata_q` are the only flops.
- Classification:
  - `is_mem` = aluop is one of the 8 listed codes.
  - `misalign` = (LH/LHU/SH with addr[0]=1) or (LW/SW with addr[1:0]≠0).
  - `go` = is_mem & !misalign.
- Transitions:
  - IDLE→BUSY on go & !bus_ack.
  - IDLE→DONE on go & bus_ack.
  - BUSY→DONE on bus_ack.
  - DONE→IDLE unconditionally; the pipeline advances at the end of DONE, so the instruction is never reissued.
  - Entering DONE from a load captures `rdata_q <= bus_rdata`.
- Bus outputs:
  - `bus_req` = (IDLE & go) | BUSY. All bus outputs are 0 when `bus_req`=0.
  - `bus_addr` = {addr[31:2],2'b00}.
  - `bus_we` = 1 for stores.
  - Byte order is big-endian: byte at addr[1:0]=00 is bits 31:24.
  - `bus_sel`:
    - Byte ops: 4'b1000>>addr[1:0].
    - Halfword ops: addr[1]=0→4'b1100, 1→4'b0011.
    - Word ops: 4'b1111.
  - `bus_wdata`: SB {4{reg2[7:0]}}, SH {2{reg2[15:0]}}, SW reg2.
- Load formatting from `rdata_q`, using the selected lane:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word.
- `mem_wdata`: formatted load data in DONE for loads; otherwise `ex_wdata`.
- `mem_wreg`:
  - For loads: `ex_wreg` & DONE.
  - Forced 0 on misalign.
  - Stores pass `ex_wreg` (0 from EX).
- `mem_wd` = `ex_wd`. HI/LO fields pass through unchanged.
- Misaligned access: no bus cycle, no stall, `align_err`=1, `mem_wreg`=0.
- `stallreq` = (IDLE & go) | BUSY.

## Timing
- Reset, asynchronous: state←IDLE, `rdata_q`←0 immediately.
- While `rst`=1 every output is 0, including `mem_*`, `bus_*`, `stallreq` and `align_err`.
- Reset asserted in BUSY abandons the transfer; `bus_req` drops in the same cycle.
- Non-memory instruction: outputs are combinational pass-through; 0 stall cycles.
- Access acked after k cycles of `bus_req` (k≥1): `stallreq` is high for k cycles, then DONE for 1 cycle. Total occupancy is k+1 cycles; `mem_wb` captures at the end of DONE.
- Zero-wait ack (ack in the first request cycle): 1 stall cycle, occupancy 2.
- `bus_ack` is ignored outside (IDLE & go) and BUSY.
- Inputs from EX/MEM are held stable by the stall while in IDLE-with-go and in BUSY. Bus outputs therefore stay stable for the whole request.
- Back-to-back memory instructions: a new instruction arrives in IDLE the cycle after DONE; no bubble beyond the per-access cost.

## Test plan
- ADDU passthrough: ex_wd=3, wreg=1, wdata=0x12345678 → same on mem_*, stallreq=0, bus_req=0 that cycle.
- LB addr=0x101, bus_rdata=0x11F2_3344, ack after 2 cycles:
  - Bus: bus_sel=0100, bus_addr=0x100, stallreq high 2 cycles.
  - DONE: mem_wdata=0xFFFFFFF2, mem_wreg=1.
- LHU addr=0x202, rdata=0xAAAA_8001, zero-wait ack → 1 stall cycle; DONE mem_wdata=0x00008001.
- SB addr=0x303, reg2=0xDEADBEEF → bus_we=1, sel=0001, wdata=0xEFEFEFEF, mem_wreg=0; returns to IDLE after DONE.
- LW addr=0x402 → align_err=1, bus_req=0, stallreq=0, mem_wreg=0.
- LW in BUSY, rst pulsed → bus_req=0 and stallreq=0 immediately. After release, state=IDLE and mem_wdata=ex_wdata passthrough.
